// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the M-to-N request encoder.
package enc_pkg;

  localparam int unsigned ENC_N = 4;
  localparam int unsigned ENC_M = 1 << ENC_N;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

endpackage : enc_pkg

// File: rtl/enc_priority_pick.sv
// Combinational pick of the first set bit of vec, searching upward from start and wrapping.
module enc_priority_pick
#(
  parameter int unsigned N = 4,
  localparam int unsigned M = 1 << N
) (
  input  logic [M-1:0] vec,
  input  logic [N-1:0] start,
  output logic         found,
  output logic [N-1:0] idx,
  output logic [M-1:0] onehot
);

  logic [N-1:0] pos;

  // Index arithmetic is N bits wide, so start + k wraps modulo M for free.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    for (int unsigned k = 0; k < M; k++) begin
      pos = N'(start + N'(k));
      if (!found && vec[pos]) begin
        found  = 1'b1;
        idx    = pos;
        onehot = M'(1) << pos;
      end
    end
  end

endmodule : enc_priority_pick

// File: rtl/encoder_mxn_arb.sv
// Sticky M-to-N request encoder with a valid/ready output handshake.
// Define ENC_ROUND_ROBIN_EN for rotating priority; default is lowest-index-first.
module encoder_mxn_arb
  import enc_pkg::*;
#(
  parameter int unsigned N = ENC_N,
  localparam int unsigned M = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic [M-1:0] pending,
  output logic         overflow
);

  state_e       state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic [M-1:0] pending_q, pending_d;
  logic         ovf_q, ovf_d;

  logic         fire_c;
  logic         grant_en_c;
  logic [M-1:0] grant_oh_c;
  logic         found_c;
  logic [N-1:0] pick_idx_c;
  logic [M-1:0] pick_oh_c;
  logic [N-1:0] start_c;

`ifdef ENC_ROUND_ROBIN_EN
  logic [N-1:0] ptr_q, ptr_d;

  // Search begins one past the last grant; pointer reset of 0 makes the first search start at 1.
  assign start_c = N'(ptr_q + N'(1));
`else
  assign start_c = '0;
`endif

  enc_priority_pick #(.N(N)) u_pick (
    .vec    (pending_q),
    .start  (start_c),
    .found  (found_c),
    .idx    (pick_idx_c),
    .onehot (pick_oh_c)
  );

  assign out_valid = (state_q == VALID);
  assign fire_c    = out_valid & out_ready;
  assign out       = out_q;
  assign pending   = pending_q;
  assign overflow  = ovf_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // Grant when idle or when the presented index is being accepted.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    grant_oh_c = '0;
    grant_en_c = (state_q == IDLE) || fire_c;
`ifdef ENC_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    if (grant_en_c) begin
      if (found_c) begin
        state_d    = VALID;
        out_d      = pick_idx_c;
        grant_oh_c = pick_oh_c;
`ifdef ENC_ROUND_ROBIN_EN
        ptr_d      = pick_idx_c;
`endif
      end else begin
        state_d = IDLE;
      end
    end
    // A new request on the granted bit is OR-ed back in, so the set wins.
    pending_d = (pending_q & ~grant_oh_c) | req;
    ovf_d     = |(req & pending_q & ~grant_oh_c);
  end

endmodule : encoder_mxn_arb

// File: tb/tb_encoder_mxn_arb.sv
// Self-checking bench for encoder_mxn_arb: directed steps plus random traffic vs. a reference model.
module tb_encoder_mxn_arb;
  import enc_pkg::*;

  localparam int N = ENC_N;
  localparam int M = 1 << N;

  logic         clk;
  logic         rst_n;
  logic [M-1:0] req;
  logic         out_ready;
  logic [N-1:0] out;
  logic         out_valid;
  logic [M-1:0] pending;
  logic         overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  bit mp[M];
  int mo;
  bit mv;
  bit movf;
  int mptr;

  encoder_mxn_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) mp[i] = 1'b0;
    mo = 0; mv = 1'b0; movf = 1'b0; mptr = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input logic [M-1:0] r, input logic rd);
    bit fire;
    bit grant;
    int gi;
    int start;
    fire  = mv && rd;
    grant = !mv || fire;
    gi    = -1;
`ifdef ENC_ROUND_ROBIN_EN
    start = (mptr + 1) % M;
`else
    start = 0;
`endif
    if (grant) begin
      for (int k = 0; k < M; k++) begin
        if (gi < 0 && mp[(start + k) % M]) gi = (start + k) % M;
      end
    end
    movf = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (r[i] && mp[i] && i != gi) movf = 1'b1;
      mp[i] = (mp[i] && i != gi) || r[i];
    end
    if (grant) begin
      if (gi >= 0) begin
        mo = gi; mv = 1'b1; mptr = gi;
      end else begin
        mv = 1'b0;
      end
    end
  endtask

  function automatic logic [M-1:0] model_pend();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = mp[i];
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(mv));
    if (mv) chk({tag, "_out"}, 32'(out), 32'(mo));
    chk({tag, "_pending"}, 32'(pending), 32'(model_pend()));
    chk({tag, "_overflow"}, 32'(overflow), 32'(movf));
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic tick(input logic [M-1:0] r, input logic rd, input string tag);
    req       = r;
    out_ready = rd;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(r, rd);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    out_ready = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 16'hFFFF;
    out_ready = 1'b0;
    model_reset();

    // Reset holds everything at zero despite active requests.
    #2;
    chk("t1_rst_out", 32'(out), 32'd0);
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_pending", 32'(pending), 32'd0);
    chk("t1_rst_overflow", 32'(overflow), 32'd0);
    tick(16'hFFFF, 1'b0, "t1_hold");
    rst_n = 1'b1;
    tick(16'hFFFF, 1'b0, "t1_e0");
    chk("t1_e0_valid", 32'(out_valid), 32'd0);
    tick(16'h0000, 1'b0, "t1_e1");
    chk("t1_e1_valid", 32'(out_valid), 32'd1);
`ifdef ENC_ROUND_ROBIN_EN
    chk("t1_e1_out", 32'(out), 32'd1);
`else
    chk("t1_e1_out", 32'(out), 32'd0);
`endif
    for (int i = 0; i < M + 1; i++) tick(16'h0000, 1'b1, "t1_drain");
    chk("t1_drained", 32'(out_valid), 32'd0);

    // Single pulse: index 3, one cycle, pending empties.
    do_reset();
    tick(16'h0008, 1'b1, "t2_a");
    tick(16'h0000, 1'b1, "t2_b");
    chk("t2_out", 32'(out), 32'd3);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_pending", 32'(pending), 32'd0);
    tick(16'h0000, 1'b1, "t2_c");
    chk("t2_valid_off", 32'(out_valid), 32'd0);

    // Three simultaneous requests delivered back to back.
    do_reset();
    tick(16'h2003, 1'b1, "t3_a");
    tick(16'h0000, 1'b1, "t3_s0");
`ifdef ENC_ROUND_ROBIN_EN
    chk("t3_seq0", 32'(out), 32'd1);
`else
    chk("t3_seq0", 32'(out), 32'd0);
`endif
    tick(16'h0000, 1'b1, "t3_s1");
`ifdef ENC_ROUND_ROBIN_EN
    chk("t3_seq1", 32'(out), 32'd13);
`else
    chk("t3_seq1", 32'(out), 32'd1);
`endif
    tick(16'h0000, 1'b1, "t3_s2");
`ifdef ENC_ROUND_ROBIN_EN
    chk("t3_seq2", 32'(out), 32'd0);
`else
    chk("t3_seq2", 32'(out), 32'd13);
`endif
    chk("t3_seq2_valid", 32'(out_valid), 32'd1);
    tick(16'h0000, 1'b1, "t3_end");
    chk("t3_end_valid", 32'(out_valid), 32'd0);

    // Backpressure holds out=7 while the same index re-pends.
    do_reset();
    tick(16'h0080, 1'b0, "t4_a");
    tick(16'h0000, 1'b0, "t4_b");
    for (int i = 0; i < 5; i++) begin
      tick((i == 2) ? 16'h0080 : 16'h0000, 1'b0, "t4_hold");
      chk("t4_hold_out", 32'(out), 32'd7);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
    end
    chk("t4_pend7", 32'(pending[7]), 32'd1);
    tick(16'h0000, 1'b1, "t4_d1");
    chk("t4_d1_out", 32'(out), 32'd7);
    chk("t4_d1_valid", 32'(out_valid), 32'd1);
    tick(16'h0000, 1'b1, "t4_d2");
    chk("t4_d2_valid", 32'(out_valid), 32'd0);

    // Duplicate request while blocked: one overflow pulse, one delivery.
    do_reset();
    tick(16'h0080, 1'b0, "t5_a");
    tick(16'h0000, 1'b0, "t5_b");
    tick(16'h0002, 1'b0, "t5_r1");
    chk("t5_ovf0", 32'(overflow), 32'd0);
    tick(16'h0002, 1'b0, "t5_r2");
    chk("t5_ovf1", 32'(overflow), 32'd1);
    tick(16'h0000, 1'b0, "t5_r3");
    chk("t5_ovf2", 32'(overflow), 32'd0);
    tick(16'h0000, 1'b1, "t5_d1");
    chk("t5_d1_out", 32'(out), 32'd1);
    tick(16'h0000, 1'b1, "t5_d2");
    chk("t5_d2_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while presenting an index.
    do_reset();
    tick(16'h00F1, 1'b0, "t6_a");
    tick(16'h0000, 1'b0, "t6_b");
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_pending", 32'(pending), 32'h00F0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_pending", 32'(pending), 32'd0);
    chk("t6_async_out", 32'(out), 32'd0);
    tick(16'h0000, 1'b1, "t6_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(16'h0000, 1'b1, "t6_post");
      chk("t6_post_valid", 32'(out_valid), 32'd0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(M'($urandom) & M'($urandom) & M'($urandom), ($urandom_range(0, 3) != 0), "rnd");
    end
    for (int i = 0; i < M + 2; i++) tick(16'h0000, 1'b1, "rnd_drain");
    chk("rnd_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_encoder_mxn_arb
